// File: rtl/capture_readout_if.sv
`default_nettype none
// -----------------------------------------------------------------------------
// Module   : capture_readout_if
// Purpose  : control, BRAM read port and byte-stream bundle for capture_readout
// Revision : 1.0 - initial release
// -----------------------------------------------------------------------------
interface capture_readout_if #(
  parameter int unsigned ADDR_W = 18
);
  logic              start;
  logic              abort;
  logic [ADDR_W-1:0] start_addr;
  logic [ADDR_W:0]   length;

  logic              bram_en;
  logic [ADDR_W-1:0] bram_addr;
  logic [7:0]        bram_dout;

  logic [7:0]        m_data;
  logic              m_valid;
  logic              m_ready;

  logic              busy;
  logic              done;
  logic [ADDR_W:0]   sent_count;

  // The readout engine is the master; the environment (BRAM, UART, host) is the slave.
  modport master (
    input  start, abort, start_addr, length, bram_dout, m_ready,
    output bram_en, bram_addr, m_data, m_valid, busy, done, sent_count
  );

  modport slave (
    output start, abort, start_addr, length, bram_dout, m_ready,
    input  bram_en, bram_addr, m_data, m_valid, busy, done, sent_count
  );
endinterface
`default_nettype wire

// File: rtl/capture_readout.sv
`default_nettype none
// -----------------------------------------------------------------------------
// Module   : capture_readout
// Purpose  : streams a 4-byte header plus a window of capture BRAM as bytes
// Revision : 1.0 - initial release
// -----------------------------------------------------------------------------
module capture_readout #(
  parameter int unsigned ADDR_W    = 18,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input  logic               clk,
  input  logic               reset,
  capture_readout_if.master  bus
);

  localparam logic [ADDR_W:0]   c_MAX_LEN  = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   c_ONE_LEN  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] c_ONE_ADDR = {{(ADDR_W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    HDR     = 3'd1,
    RD_REQ  = 3'd2,
    RD_WAIT = 3'd3,
    SEND    = 3'd4,
    FIN     = 3'd5
  } state_t;

  state_t            r_state,      w_state_nxt;
  logic [ADDR_W-1:0] r_cur_addr,   w_cur_addr_nxt;
  logic [ADDR_W:0]   r_remaining,  w_remaining_nxt;
  logic [1:0]        r_hdr_idx,    w_hdr_idx_nxt;
  logic [7:0]        r_m_data,     w_m_data_nxt;
  logic              r_m_valid,    w_m_valid_nxt;
  logic              r_bram_en,    w_bram_en_nxt;
  logic [ADDR_W-1:0] r_bram_addr,  w_bram_addr_nxt;
  logic              r_busy,       w_busy_nxt;
  logic              r_done,       w_done_nxt;
  logic [ADDR_W:0]   r_sent_count, w_sent_count_nxt;

  logic [ADDR_W:0]   w_len_clamped;

  // Header byte idx of a dump whose clamped payload length is len.
  function automatic logic [7:0] hdr_byte(input logic [1:0] idx, input logic [ADDR_W:0] len);
    case (idx)
      2'd0:    hdr_byte = SYNC_BYTE;
      2'd1:    hdr_byte = 8'(len >> 16) & 8'h07;
      2'd2:    hdr_byte = 8'(len >> 8);
      default: hdr_byte = 8'(len);
    endcase
  endfunction

  assign w_len_clamped = bus.length[ADDR_W] ? c_MAX_LEN : bus.length;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_cur_addr   <= '0;
      r_remaining  <= '0;
      r_hdr_idx    <= '0;
      r_m_data     <= '0;
      r_m_valid    <= 1'b0;
      r_bram_en    <= 1'b0;
      r_bram_addr  <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_sent_count <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_cur_addr   <= w_cur_addr_nxt;
      r_remaining  <= w_remaining_nxt;
      r_hdr_idx    <= w_hdr_idx_nxt;
      r_m_data     <= w_m_data_nxt;
      r_m_valid    <= w_m_valid_nxt;
      r_bram_en    <= w_bram_en_nxt;
      r_bram_addr  <= w_bram_addr_nxt;
      r_busy       <= w_busy_nxt;
      r_done       <= w_done_nxt;
      r_sent_count <= w_sent_count_nxt;
    end
  end

  // Every output is a register, so each branch computes the value the output
  // must carry while the FSM sits in the state it is moving to.
  always_comb begin
    w_state_nxt      = r_state;
    w_cur_addr_nxt   = r_cur_addr;
    w_remaining_nxt  = r_remaining;
    w_hdr_idx_nxt    = r_hdr_idx;
    w_m_data_nxt     = r_m_data;
    w_m_valid_nxt    = r_m_valid;
    w_bram_en_nxt    = 1'b0;
    w_bram_addr_nxt  = r_bram_addr;
    w_done_nxt       = 1'b0;
    w_sent_count_nxt = r_sent_count;

    if (bus.abort) begin
      w_state_nxt   = IDLE;
      w_m_valid_nxt = 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            w_state_nxt      = HDR;
            w_cur_addr_nxt   = bus.start_addr;
            w_remaining_nxt  = w_len_clamped;
            w_sent_count_nxt = '0;
            w_hdr_idx_nxt    = 2'd0;
            w_m_data_nxt     = hdr_byte(2'd0, w_len_clamped);
            w_m_valid_nxt    = 1'b1;
          end
        end

        HDR: begin
          if (bus.m_ready) begin
            if (r_hdr_idx == 2'd3) begin
              w_m_valid_nxt = 1'b0;
              if (r_remaining == '0) begin
                w_state_nxt = FIN;
                w_done_nxt  = 1'b1;
              end else begin
                w_state_nxt     = RD_REQ;
                w_bram_en_nxt   = 1'b1;
                w_bram_addr_nxt = r_cur_addr;
              end
            end else begin
              w_hdr_idx_nxt = r_hdr_idx + 2'd1;
              w_m_data_nxt  = hdr_byte(r_hdr_idx + 2'd1, r_remaining);
            end
          end
        end

        RD_REQ: begin
          w_state_nxt = RD_WAIT;
        end

        RD_WAIT: begin
          w_state_nxt   = SEND;
          w_m_data_nxt  = bus.bram_dout;
          w_m_valid_nxt = 1'b1;
        end

        SEND: begin
          if (bus.m_ready) begin
            w_m_valid_nxt    = 1'b0;
            w_cur_addr_nxt   = r_cur_addr + c_ONE_ADDR;
            w_remaining_nxt  = r_remaining - c_ONE_LEN;
            w_sent_count_nxt = r_sent_count + c_ONE_LEN;
            if (r_remaining == c_ONE_LEN) begin
              w_state_nxt = FIN;
              w_done_nxt  = 1'b1;
            end else begin
              w_state_nxt     = RD_REQ;
              w_bram_en_nxt   = 1'b1;
              w_bram_addr_nxt = r_cur_addr + c_ONE_ADDR;
            end
          end
        end

        FIN: begin
          w_state_nxt = IDLE;
        end

        default: begin
          w_state_nxt   = IDLE;
          w_m_valid_nxt = 1'b0;
        end
      endcase
    end

    w_busy_nxt = (w_state_nxt != IDLE);
  end

  assign bus.bram_en    = r_bram_en;
  assign bus.bram_addr  = r_bram_addr;
  assign bus.m_data     = r_m_data;
  assign bus.m_valid    = r_m_valid;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.sent_count = r_sent_count;

endmodule
`default_nettype wire

// File: tb/tb_capture_readout.sv
`default_nettype none
// -----------------------------------------------------------------------------
// Module   : tb_capture_readout
// Purpose  : directed bench for capture_readout with a behavioural BRAM model
// Revision : 1.0 - initial release
// -----------------------------------------------------------------------------
module tb_capture_readout;

  localparam int ADDR_W = 18;
  localparam int DEPTH  = 1 << ADDR_W;

  typedef struct {
    string             name;
    logic [ADDR_W-1:0] saddr;
    logic [ADDR_W:0]   len;
    int                rmode;
    logic [31:0]       hdr;
    int                exp_n;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  capture_readout_if #(.ADDR_W(ADDR_W)) bus ();

  capture_readout #(.ADDR_W(ADDR_W), .SYNC_BYTE(8'hA5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_chk = 0;
  int n_pass = 0;
  int rdy_mode = 0;
  logic [7:0] mem [DEPTH];

  logic [7:0]        rx[$];
  logic [ADDR_W-1:0] aq[$];
  int done_cnt = 0;
  int stall_err = 0;
  int rx_base, aq_base, done_base;

  // BRAM model: one-cycle read latency.
  always @(posedge clk) begin
    if (bus.bram_en) bus.bram_dout <= mem[bus.bram_addr];
  end

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       bus.m_ready = 1'b1;
      1:       bus.m_ready = 1'($urandom_range(0, 1));
      default: bus.m_ready = 1'b0;
    endcase
  end

  logic       pv = 1'b0, pr = 1'b0, pab = 1'b0, prs = 1'b1;
  logic [7:0] pd = 8'h00;
  always @(negedge clk) begin
    if (bus.m_valid && bus.m_ready) rx.push_back(bus.m_data);
    if (bus.bram_en) aq.push_back(bus.bram_addr);
    if (bus.done) done_cnt++;
    if (pv && !pr && !pab && !prs && !(bus.m_valid && bus.m_data == pd)) stall_err++;
    pv  = bus.m_valid;
    pr  = bus.m_ready;
    pd  = bus.m_data;
    pab = bus.abort;
    prs = reset;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mark();
    rx_base   = rx.size();
    aq_base   = aq.size();
    done_base = done_cnt;
  endtask

  task automatic do_start(input logic [ADDR_W-1:0] a, input logic [ADDR_W:0] l);
    bus.start      = 1'b1;
    bus.start_addr = a;
    bus.length     = l;
    tick();
    bus.start      = 1'b0;
    bus.start_addr = ADDR_W'($urandom);
    bus.length     = (ADDR_W+1)'($urandom);
  endtask

  task automatic wait_done(input int budget);
    for (int k = 0; k < budget; k++) begin
      tick();
      if (done_cnt > done_base) break;
    end
  endtask

  task automatic wait_rx(input string name, input int n, input int budget);
    bit ok = 1'b0;
    for (int k = 0; k < budget && !ok; k++) begin
      tick();
      ok = (rx.size() - rx_base >= n);
    end
    check({name, "_rx_wait"}, 64'(ok), 64'd1);
  endtask

  task automatic wait_valid(input string name, input int budget);
    bit ok = 1'b0;
    for (int k = 0; k < budget && !ok; k++) begin
      tick();
      ok = (bus.m_valid === 1'b1);
    end
    check({name, "_valid_wait"}, 64'(ok), 64'd1);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_m_valid"},    64'(bus.m_valid),    64'd0);
    check({name, "_m_data"},     64'(bus.m_data),     64'd0);
    check({name, "_bram_en"},    64'(bus.bram_en),    64'd0);
    check({name, "_bram_addr"},  64'(bus.bram_addr),  64'd0);
    check({name, "_busy"},       64'(bus.busy),       64'd0);
    check({name, "_done"},       64'(bus.done),       64'd0);
    check({name, "_sent_count"}, 64'(bus.sent_count), 64'd0);
  endtask

  function automatic logic [31:0] hdr_seen();
    if (rx.size() >= rx_base + 4)
      return {rx[rx_base], rx[rx_base+1], rx[rx_base+2], rx[rx_base+3]};
    return 32'h0;
  endfunction

  task automatic run_vec(input vec_t v);
    int perr = 0;
    int aerr = 0;
    mark();
    rdy_mode = v.rmode;
    do_start(v.saddr, v.len);
    wait_done(8 * v.exp_n + 100);
    check({v.name, "_done_count"}, 64'(done_cnt - done_base), 64'd1);
    check({v.name, "_done_width"}, 64'(bus.done), 64'd0);
    check({v.name, "_busy_after"}, 64'(bus.busy), 64'd0);
    check({v.name, "_header"}, 64'(hdr_seen()), 64'(v.hdr));
    check({v.name, "_n_bytes"}, 64'(rx.size() - rx_base), 64'(4 + v.exp_n));
    check({v.name, "_n_reads"}, 64'(aq.size() - aq_base), 64'(v.exp_n));
    for (int i = 0; i < v.exp_n; i++) begin
      logic [ADDR_W-1:0] ad;
      ad = v.saddr + ADDR_W'(i);
      if (rx.size() <= rx_base + 4 + i || rx[rx_base+4+i] !== mem[ad]) perr++;
      if (aq.size() <= aq_base + i || aq[aq_base+i] !== ad) aerr++;
    end
    check({v.name, "_payload_errs"}, 64'(perr), 64'd0);
    check({v.name, "_addr_errs"}, 64'(aerr), 64'd0);
    check({v.name, "_sent_count"}, 64'(bus.sent_count), 64'(v.exp_n));
    rdy_mode = 0;
    tick();
  endtask

  vec_t vecs[6];

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{"basic",     18'h00010, 19'h00003, 0, 32'hA5000003, 3};
    vecs[1] = '{"wrap",      18'h3FFFE, 19'h00004, 0, 32'hA5000004, 4};
    vecs[2] = '{"zero_len",  18'h00123, 19'h00000, 0, 32'hA5000000, 0};
    vecs[3] = '{"one_top",   18'h3FFFF, 19'h00001, 1, 32'hA5000001, 1};
    vecs[4] = '{"long_rand", 18'h01F00, 19'h00201, 1, 32'hA5000201, 513};
    vecs[5] = '{"mid_rand",  18'h2ABCD, 19'h00010, 1, 32'hA5000010, 16};

    for (int i = 0; i < DEPTH; i++) mem[i] = 8'((i * 37) ^ (i >> 9));
    mem[18'h00010] = 8'h11;
    mem[18'h00011] = 8'h22;
    mem[18'h00012] = 8'h33;

    reset = 1'b1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.start_addr = '0;
    bus.length = '0;
    repeat (3) tick();
    check_reset_outputs("reset");
    reset = 1'b0;
    tick();

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Backpressure: hold m_ready low for 5 cycles on the second payload byte.
    mark();
    do_start(18'h00010, 19'd3);
    wait_rx("stall", 5, 100);
    rdy_mode = 2;
    wait_valid("stall", 20);
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", 64'(bus.m_valid), 64'd1);
      check("stall_data", 64'(bus.m_data), 64'h22);
      tick();
    end
    rdy_mode = 0;
    wait_done(100);
    check("stall_done", 64'(done_cnt - done_base), 64'd1);
    check("stall_n_bytes", 64'(rx.size() - rx_base), 64'd7);
    if (rx.size() >= rx_base + 7)
      check("stall_stream", {8'h0, rx[rx_base], rx[rx_base+1], rx[rx_base+2],
            rx[rx_base+3], rx[rx_base+4], rx[rx_base+5], rx[rx_base+6]},
            64'h00A5000003112233);
    check("stall_sent_count", 64'(bus.sent_count), 64'd3);
    check("stall_hold_errs", 64'(stall_err), 64'd0);

    // Oversized length clamps to 2^ADDR_W; abort once the header is out.
    mark();
    do_start(18'h00000, 19'h7FFFF);
    rdy_mode = 0;
    wait_rx("clamp", 4, 50);
    check("clamp_header", 64'(hdr_seen()), 64'hA5040000);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check("clamp_abort_busy", 64'(bus.busy), 64'd0);
    check("clamp_abort_valid", 64'(bus.m_valid), 64'd0);

    // Abort after two payload bytes, then a clean dump.
    mark();
    do_start(18'h00100, 19'd5);
    begin
      bit ok = 1'b0;
      for (int k = 0; k < 100 && !ok; k++) begin
        tick();
        ok = (bus.sent_count == 19'd2);
      end
      check("abort_wait", 64'(ok), 64'd1);
    end
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check("abort_busy", 64'(bus.busy), 64'd0);
    check("abort_m_valid", 64'(bus.m_valid), 64'd0);
    check("abort_bram_en", 64'(bus.bram_en), 64'd0);
    check("abort_sent_count", 64'(bus.sent_count), 64'd2);
    repeat (4) tick();
    check("abort_no_done", 64'(done_cnt - done_base), 64'd0);
    check("abort_sent_hold", 64'(bus.sent_count), 64'd2);
    check("abort_n_bytes", 64'(rx.size() - rx_base), 64'd6);
    run_vec(vecs[0]);

    // start together with abort in IDLE stays idle.
    bus.start = 1'b1;
    bus.abort = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.abort = 1'b0;
    check("start_abort_busy", 64'(bus.busy), 64'd0);
    tick();
    check("start_abort_valid", 64'(bus.m_valid), 64'd0);

    // Reset in SEND, with a start pulse while busy that must be ignored.
    mark();
    do_start(18'h00010, 19'd4);
    wait_rx("rst", 4, 50);
    rdy_mode = 2;
    wait_valid("rst", 20);
    check("rst_first_byte", 64'(bus.m_data), 64'h11);
    bus.start = 1'b1;
    bus.start_addr = 18'h00000;
    bus.length = 19'd1;
    tick();
    bus.start = 1'b0;
    check("busy_start_valid", 64'(bus.m_valid), 64'd1);
    check("busy_start_data", 64'(bus.m_data), 64'h11);
    check("busy_start_busy", 64'(bus.busy), 64'd1);
    reset = 1'b1;
    tick();
    check_reset_outputs("mid_reset");
    reset = 1'b0;
    rdy_mode = 0;
    repeat (5) tick();
    check("mid_reset_no_done", 64'(done_cnt - done_base), 64'd0);
    check("mid_reset_idle", 64'(bus.busy), 64'd0);
    run_vec(vecs[1]);

    check("final_hold_errs", 64'(stall_err), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
